data_bus_responder: RTL and testbench



---
 rtl/data_bus_responder.sv | 108 ++++++++++
 tb/tb_data_bus_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-bus responder: word RAM, cycle counter and console byte FIFO
// behind a combinational read / posedge write memory port.
module data_bus_responder #(
  parameter int RAM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  localparam int RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  localparam logic [16:0] RAM_TOP  = 17'(RAM_DEPTH);
  localparam logic [CW-1:0] FULL_N = CW'(FIFO_DEPTH);

  localparam logic [15:0] A_CYCLE  = 16'hFF00;
  localparam logic [15:0] A_TX     = 16'hFF01;
  localparam logic [15:0] A_STATUS = 16'hFF02;
  localparam logic [15:0] A_COUNT  = 16'hFF03;

  logic [31:0]   ram [RAM_DEPTH];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycle;

  logic           ram_hit;
  logic [RAW-1:0] ram_idx;
  logic           wr_cycle;
  logic           wr_tx;
  logic           wr_status;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;

  assign ram_hit   = {1'b0, i_address} < RAM_TOP;
  assign ram_idx   = i_address[RAW-1:0];
  assign wr_cycle  = i_rw && (i_address == A_CYCLE);
  assign wr_tx     = i_rw && (i_address == A_TX);
  assign wr_status = i_rw && (i_address == A_STATUS);

  assign empty = (count == '0);
  assign full  = (count == FULL_N);
  assign pop   = !empty && i_tx_ready;
  // A pop frees the slot, so a push into a full FIFO still lands
  assign push  = wr_tx && (!full || pop);

  assign o_tx_valid = !empty;
  assign o_tx_data  = empty ? 8'h00 : fifo[rd_ptr];

  // RAM has no reset and commits even while reset is asserted
  always_ff @(posedge i_clk) begin
    if (i_rw && ram_hit) ram[ram_idx] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && push) fifo[wr_ptr] <= i_data[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (wr_tx && full && !pop) overflow <= 1'b1;
      else if (wr_status && i_data[2]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cycle <= '0;
    else if (wr_cycle) cycle <= i_data;
    else cycle <= cycle + 32'd1;
  end

  always_comb begin
    o_data = '0;
    unique case (1'b1)
      ram_hit:                o_data = ram[ram_idx];
      i_address == A_CYCLE:  o_data = cycle;
      i_address == A_STATUS: o_data = {29'b0, overflow, full, empty};
      i_address == A_COUNT:  o_data = 32'(count);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed plan steps then random
// traffic, checked against a queue-based reference model.
module tb_data_bus_responder;

  localparam int RD = 1024;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rw;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tv;
  logic [7:0]  td;
  logic        rdy;

  data_bus_responder #(
    .RAM_DEPTH(RD),
    .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_address(addr),
    .i_rw(rw),
    .i_data(wdata),
    .o_data(rdata),
    .o_tx_valid(tv),
    .o_tx_data(td),
    .i_tx_ready(rdy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mram [int];
  logic [31:0] mcyc;
  logic [7:0]  q [$];
  bit          movf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit mread(input logic [15:0] a,
                               output logic [31:0] v);
    v = '0;
    if (int'(a) < RD) begin
      if (!mram.exists(int'(a))) return 1'b0;
      v = mram[int'(a)];
      return 1'b1;
    end
    case (a)
      16'hFF00: v = mcyc;
      16'hFF02: v = {29'b0, movf, q.size() == FD, q.size() == 0};
      16'hFF03: v = 32'(q.size());
      default:  v = '0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit pop;
    bit full;
    if (rw && int'(addr) < RD) mram[int'(addr)] = wdata;
    if (rst) begin
      q.delete();
      movf = 1'b0;
      mcyc = '0;
    end else begin
      pop  = (q.size() != 0) && rdy;
      full = (q.size() == FD);
      if (pop) void'(q.pop_front());
      if (rw && addr == 16'hFF01) begin
        if (!full || pop) q.push_back(wdata[7:0]);
        else movf = 1'b1;
      end
      if (rw && addr == 16'hFF02 && wdata[2]) movf = 1'b0;
      if (rw && addr == 16'hFF00) mcyc = wdata;
      else mcyc = mcyc + 32'd1;
    end
  endtask

  // One bus cycle: check outputs mid-cycle, then advance model at the edge
  task automatic step(input bit lit_en, input logic [31:0] lit,
                      input string tag);
    logic [31:0] v;
    @(negedge clk);
    if (mread(addr, v)) chk("rdata", rdata, v);
    chk("tx_valid", 32'(tv), 32'(q.size() != 0));
    chk("tx_data", 32'(td), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    if (lit_en) chk(tag, rdata, lit);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd(input logic [15:0] a);
    rw = 1'b0; addr = a; wdata = $urandom;
    step(1'b0, '0, "");
  endtask

  task automatic rd_lit(input logic [15:0] a, input logic [31:0] e,
                        input string tag);
    rw = 1'b0; addr = a; wdata = $urandom;
    step(1'b1, e, tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    rw = 1'b1; addr = a; wdata = d;
    step(1'b0, '0, "");
    rw = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rw = 1'b0; addr = '0; wdata = '0; rdy = 1'b0;
    mcyc = '0; movf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state and cycle count
    rd_lit(16'hFF02, 32'h1, "status_rst");
    for (int i = 0; i < 8; i++) rd(16'hFF00);
    rd_lit(16'hFF00, 32'd9, "cycle_10th");

    // RAM write, readback, read-during-write
    wr(16'h0005, 32'hDEADBEEF);
    rd_lit(16'h0005, 32'hDEADBEEF, "ram_rd");
    rw = 1'b1; addr = 16'h0005; wdata = 32'h12345678;
    step(1'b1, 32'hDEADBEEF, "ram_rdw_old");
    rd_lit(16'h0005, 32'h12345678, "ram_rdw_new");

    // cycle load and wrap
    wr(16'hFF00, 32'hFFFFFFFE);
    rd_lit(16'hFF00, 32'hFFFFFFFE, "cyc_load");
    rd_lit(16'hFF00, 32'hFFFFFFFF, "cyc_max");
    rd_lit(16'hFF00, 32'h0, "cyc_wrap");

    // fill, overflow, clear
    for (int i = 0; i < 8; i++) wr(16'hFF01, 32'hAB00_0041 + 32'(i));
    rd_lit(16'hFF02, 32'h2, "status_full");
    rd_lit(16'hFF03, 32'd8, "count_full");
    wr(16'hFF01, 32'h49);
    rd_lit(16'hFF02, 32'h6, "status_ovf");
    rd_lit(16'hFF03, 32'd8, "count_ovf");
    wr(16'hFF02, 32'h4);
    rd_lit(16'hFF02, 32'h2, "status_clr");

    // drain order
    rdy = 1'b1;
    addr = 16'hFF03;
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", 32'(td), 32'h41 + 32'(i));
      rd(16'hFF03);
    end
    chk("drain_empty", 32'(tv), 32'h0);
    rd_lit(16'hFF02, 32'h1, "status_drained");

    // full FIFO with simultaneous push and pop
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) wr(16'hFF01, 32'h61 + 32'(i));
    rdy = 1'b1;
    wr(16'hFF01, 32'h5A);
    rdy = 1'b0;
    rd_lit(16'hFF03, 32'd8, "count_pushpop");
    rd_lit(16'hFF02, 32'h2, "status_pushpop");
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("last_5a", 32'(td), 32'h5A);
      rd(16'hFF03);
    end

    // reset mid-drain, register write ignored, RAM write kept
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) wr(16'hFF01, 32'h30 + 32'(i));
    rdy = 1'b1;
    rd(16'hFF03);
    rd(16'hFF03);
    rst = 1'b1;
    wr(16'hFF00, 32'h0000_1234);
    wr(16'h0007, 32'hCAFEF00D);
    rst = 1'b0;
    chk("rst_valid", 32'(tv), 32'h0);
    chk("rst_data", 32'(td), 32'h0);
    rd_lit(16'hFF00, 32'h0, "rst_cycle");
    rd_lit(16'hFF03, 32'h0, "rst_count");
    rd_lit(16'h0005, 32'h12345678, "rst_ram_kept");
    rd_lit(16'h0007, 32'hCAFEF00D, "rst_ram_wr");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int sel;
      rst = ($urandom_range(0, 63) == 0);
      rdy = $urandom_range(0, 1) == 1;
      rw = $urandom_range(0, 1) == 1;
      wdata = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel < 3) addr = 16'($urandom_range(0, 15));
      else if (sel == 3) addr = 16'($urandom_range(16'h0400, 16'hFEFF));
      else if (sel == 4) addr = 16'($urandom_range(16'hFF04, 16'hFFFF));
      else if (sel == 5) addr = 16'hFF01;
      else addr = 16'hFF00 + 16'($urandom_range(0, 3));
      if (addr == 16'hFF00 && $urandom_range(0, 3) != 0) rw = 1'b0;
      step(1'b0, '0, "");
    end
    rst = 1'b0;
    rw = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
